hough_rho_sweep: RTL and testbench
==================================

Name: hough_rho_sweep

Overview:
- Per-edge-pixel rho generator for the Hough transform accumulator path.
- Accepts one edge pixel (x, y) at a time and sweeps all theta bins.
- Emits a stream of (theta index, rho bin index) pairs, LANES thetas per beat, to the accumulator-update stage.
- Replaces the runtime CORDIC path with an elaboration-time trig ROM and a stallable 3-stage multiply-add pipeline with valid/ready on both sides.

Parameters:
- X_WIDTH, 10, width of unsigned pixel x coordinate.
- Y_WIDTH, 10, width of unsigned pixel y coordinate.
- THETAS, 180, number of theta bins; bin t = t*180/THETAS degrees.
- LANES, 1, thetas computed per output beat; must divide THETAS, else elaboration error.
- TRIG_FRAC, 12, fraction bits of signed sin/cos ROM entries (entry width TRIG_FRAC+2).
- RHO_SHIFT, 1, log2 of rho resolution; rho is divided by 2^RHO_SHIFT.
- RHOS, 1024, number of rho bins; offset RHOS/2 centres rho=0.
- Derived (localparam): THETA_W = clog2(THETAS), RHO_W = clog2(RHOS).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel available.
- in_ready  out  1  block can accept a pixel.
- in_x  in  X_WIDTH  pixel x.
- in_y  in  Y_WIDTH  pixel y.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_theta  out  LANES*THETA_W  theta index per lane; lane k in bits [k*THETA_W +: THETA_W].
- out_rho  out  LANES*RHO_W  rho bin index per lane.
- out_rho_ok  out  LANES  lane rho inside [0, RHOS-1].
- out_last  out  1  final beat of the current pixel.
- busy  out  1  sweep in progress or pipeline not empty.

Behaviour:
- Reset (reset low, asynchronous): FSM to IDLE. All pipeline valids cleared. out_valid=0, out_last=0, out_theta=0, out_rho=0, out_rho_ok=0, busy=0, in_ready=0 while asserted. Pixel in flight is dropped. in_ready=1 the first cycle after release.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch x,y, clear theta_base, go to SWEEP.
  - SWEEP: issue one theta group per enabled cycle into S1, then theta_base += LANES. After issuing group THETAS-LANES, go to DRAIN.
  - DRAIN: wait until the beat carrying out_last handshakes, then go to IDLE.
  - in_ready=0 outside IDLE. No pixel overlap.
- Pipeline stages, all gated by en = !out_valid || out_ready:
  - S1: registered ROM read of cos[t], sin[t] per lane. ROM value = round(cos|sin(pi*t/THETAS) * 2^TRIG_FRAC), computed at elaboration.
  - S2: registered signed products x*cos and y*sin, width X_WIDTH+TRIG_FRAC+3 (resp. Y_WIDTH).
  - S3/output register: sum (one extra bit), arithmetic right shift by TRIG_FRAC+RHO_SHIFT (floor), add RHOS/2 to give idx.
- Range check: if 0 <= idx < RHOS then out_rho=idx[RHO_W-1:0] and out_rho_ok=1; otherwise out_rho=0 and out_rho_ok=0.
- Latency: with out_ready held 1, the first beat's out_valid rises 3 cycles after the input handshake edge. Beats then follow back to back, THETAS/LANES beats per pixel.
- Next in_ready rises the cycle after the out_last handshake. Minimum pixel period = THETAS/LANES + 4 cycles.
- Backpressure: while out_valid && !out_ready, all out_* and internal stages hold stable. No beat is dropped or duplicated.
- out_last=1 only on the beat whose lane 0 theta = THETAS-LANES.
- busy=1 from input handshake until the out_last handshake inclusive.
- in_valid while in_ready=0: ignored, in_x/in_y not sampled.

Test Plan:
- THETAS=180, LANES=1, RHO_SHIFT=1, RHOS=1024, TRIG_FRAC=12; pixel (0,0), out_ready=1 -> 180 beats, theta 0..179, all rho=512 and ok=1, first out_valid 3 cycles after accept, out_last only on theta 179.
- Pixel (100,0) -> theta 0 rho=562; theta 90 rho=512; theta 179 rho=462 (floor(-409500/8192) = -50).
- Pixel (0,200) -> theta 90 rho=612; theta 0 rho=512.
- Pixel (100,0), out_ready random 50% -> exactly 180 handshaked beats with values identical to the no-stall run; outputs stable during every stall; in_ready stays 0 until after the out_last handshake.
- LANES=4 -> 45 beats; lane k theta = 4*beat + k; per-lane rho matches the LANES=1 reference values.
- RHOS=64 with pixel (1000,0) -> theta 0 ok=0 and rho=0. Separately, drive reset low at beat 50 -> out_valid=0 and busy=0 immediately; in_ready=1 one cycle after release; the next pixel sweeps from theta 0.

Source files
------------

// File: rtl/hough_rho_sweep.sv
// Per-pixel Hough rho generator: sweeps every theta bin through an elaboration-time
// trig ROM and a stallable 3-stage multiply-add pipeline, LANES thetas per beat.
module hough_rho_sweep #(
  parameter int unsigned X_WIDTH   = 10,
  parameter int unsigned Y_WIDTH   = 10,
  parameter int unsigned THETAS    = 180,
  parameter int unsigned LANES     = 1,
  parameter int unsigned TRIG_FRAC = 12,
  parameter int unsigned RHO_SHIFT = 1,
  parameter int unsigned RHOS      = 1024
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [X_WIDTH-1:0]                  in_x,
  input  logic [Y_WIDTH-1:0]                  in_y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*$clog2(THETAS)-1:0]     out_theta,
  output logic [LANES*$clog2(RHOS)-1:0]       out_rho,
  output logic [LANES-1:0]                    out_rho_ok,
  output logic                                out_last,
  output logic                                busy
);

  localparam int unsigned THETA_W   = $clog2(THETAS);
  localparam int unsigned RHO_W     = $clog2(RHOS);
  localparam int unsigned TRIG_W    = TRIG_FRAC + 2;
  localparam int unsigned PX_W      = X_WIDTH + TRIG_FRAC + 3;
  localparam int unsigned PY_W      = Y_WIDTH + TRIG_FRAC + 3;
  localparam int unsigned SUM_W     = ((PX_W > PY_W) ? PX_W : PY_W) + 1;
  localparam int unsigned IDX_W     = ((SUM_W > RHO_W) ? SUM_W : RHO_W) + 2;
  localparam int unsigned SHIFT     = TRIG_FRAC + RHO_SHIFT;
  localparam int unsigned LAST_BASE = THETAS - LANES;
  localparam logic signed [IDX_W-1:0] RHO_OFFSET = IDX_W'(RHOS / 2);
  localparam logic signed [IDX_W-1:0] RHO_LIMIT  = IDX_W'(RHOS);
  localparam real PI = 3.14159265358979323846;

  if (THETAS % LANES != 0) begin : g_lanes_check
    $error("hough_rho_sweep: LANES must divide THETAS");
  end

  // Rounded fixed-point cos/sin table over [0, pi), built with a Taylor series at elaboration.
  function automatic logic [THETAS*TRIG_W-1:0] build_rom(input bit use_sin);
    logic [THETAS*TRIG_W-1:0] tab;
    real ang;
    real x2;
    real term_s;
    real term_c;
    real s;
    real c;
    real v;
    int  q;
    tab = '0;
    for (int t = 0; t < int'(THETAS); t++) begin
      ang    = PI * real'(t) / real'(THETAS);
      x2     = ang * ang;
      term_c = 1.0;
      c      = 1.0;
      term_s = ang;
      s      = ang;
      for (int n = 1; n < 24; n++) begin
        term_c = 0.0 - term_c * x2 / real'((2 * n - 1) * (2 * n));
        term_s = 0.0 - term_s * x2 / real'((2 * n) * (2 * n + 1));
        c      = c + term_c;
        s      = s + term_s;
      end
      v = (use_sin ? s : c) * real'(1 << TRIG_FRAC);
      q = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      tab[t*TRIG_W +: TRIG_W] = TRIG_W'(q);
    end
    return tab;
  endfunction

  localparam logic [THETAS*TRIG_W-1:0] COS_ROM = build_rom(1'b0);
  localparam logic [THETAS*TRIG_W-1:0] SIN_ROM = build_rom(1'b1);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN} state_t;

  state_t               state;
  state_t               next_state;
  logic                 en;
  logic                 accept;
  logic                 issue;
  logic                 last_issue;
  logic                 in_ready_d;
  logic                 busy_d;
  logic [X_WIDTH-1:0]   x_q;
  logic [Y_WIDTH-1:0]   y_q;
  logic [THETA_W-1:0]   theta_base;
  logic [THETA_W-1:0]   lane_t [LANES];

  assign en         = !out_valid || out_ready;
  assign last_issue = (theta_base == THETA_W'(LAST_BASE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (in_valid && in_ready) next_state = ST_SWEEP;
      ST_SWEEP: if (en && last_issue) next_state = ST_DRAIN;
      ST_DRAIN: if (out_valid && out_ready && out_last) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    accept     = 1'b0;
    issue      = 1'b0;
    in_ready_d = (next_state == ST_IDLE);
    busy_d     = (next_state != ST_IDLE);
    unique case (state)
      ST_IDLE:  accept = in_valid && in_ready;
      ST_SWEEP: issue  = en;
      default:  ;
    endcase
  end

  // Pixel latch and theta group counter; the counter wraps so ROM reads stay in range.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      theta_base <= '0;
    end else begin
      in_ready <= in_ready_d;
      busy     <= busy_d;
      if (accept) begin
        x_q        <= in_x;
        y_q        <= in_y;
        theta_base <= '0;
      end else if (issue) begin
        theta_base <= last_issue ? '0 : theta_base + THETA_W'(LANES);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(LANES); k++) lane_t[k] = theta_base + THETA_W'(k);
  end

  // S1: registered ROM read.
  logic                       v1;
  logic                       last1;
  logic [LANES*THETA_W-1:0]   theta1;
  logic signed [TRIG_W-1:0]   cos1 [LANES];
  logic signed [TRIG_W-1:0]   sin1 [LANES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1     <= 1'b0;
      last1  <= 1'b0;
      theta1 <= '0;
      for (int k = 0; k < int'(LANES); k++) begin
        cos1[k] <= '0;
        sin1[k] <= '0;
      end
    end else if (en) begin
      v1    <= issue;
      last1 <= issue && last_issue;
      for (int k = 0; k < int'(LANES); k++) begin
        theta1[k*THETA_W +: THETA_W] <= lane_t[k];
        cos1[k] <= COS_ROM[lane_t[k]*TRIG_W +: TRIG_W];
        sin1[k] <= SIN_ROM[lane_t[k]*TRIG_W +: TRIG_W];
      end
    end
  end

  // S2: signed products of the unsigned coordinates with the trig terms.
  logic                       v2;
  logic                       last2;
  logic [LANES*THETA_W-1:0]   theta2;
  logic signed [PX_W-1:0]     px2 [LANES];
  logic signed [PY_W-1:0]     py2 [LANES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v2     <= 1'b0;
      last2  <= 1'b0;
      theta2 <= '0;
      for (int k = 0; k < int'(LANES); k++) begin
        px2[k] <= '0;
        py2[k] <= '0;
      end
    end else if (en) begin
      v2     <= v1;
      last2  <= last1;
      theta2 <= theta1;
      for (int k = 0; k < int'(LANES); k++) begin
        px2[k] <= PX_W'($signed({1'b0, x_q})) * PX_W'(cos1[k]);
        py2[k] <= PY_W'($signed({1'b0, y_q})) * PY_W'(sin1[k]);
      end
    end
  end

  // S3 combinational: floor-scaled sum, centred, then range-checked.
  logic signed [SUM_W-1:0]    sum_c [LANES];
  logic signed [IDX_W-1:0]    idx_c [LANES];
  logic [LANES-1:0]           ok_c;
  logic [LANES*RHO_W-1:0]     rho_c;

  always_comb begin
    ok_c  = '0;
    rho_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      sum_c[k] = SUM_W'(px2[k]) + SUM_W'(py2[k]);
      idx_c[k] = IDX_W'(sum_c[k] >>> SHIFT) + RHO_OFFSET;
      ok_c[k]  = !idx_c[k][IDX_W-1] && (idx_c[k] < RHO_LIMIT);
      if (ok_c[k]) rho_c[k*RHO_W +: RHO_W] = idx_c[k][RHO_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_theta  <= '0;
      out_rho    <= '0;
      out_rho_ok <= '0;
    end else if (en) begin
      out_valid  <= v2;
      out_last   <= v2 && last2;
      out_theta  <= theta2;
      out_rho    <= rho_c;
      out_rho_ok <= ok_c;
    end
  end

endmodule

// File: tb/tb_hough_rho_sweep.sv
// Scoreboard bench for hough_rho_sweep: default build, a 4-lane build and a 64-bin build.
module tb_hough_rho_sweep;

  typedef struct {
    int theta;
    int rho;
    bit ok;
    bit last;
  } exp_t;

  typedef struct {
    bit valid;
    bit last;
    bit in_ready;
    bit busy;
    int theta [4];
    int rho   [4];
    bit ok    [4];
  } obs_t;

  logic clock;
  logic reset;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, out_last0, busy0;
  logic [9:0]  in_x0, in_y0;
  logic [7:0]  out_theta0;
  logic [9:0]  out_rho0;
  logic [0:0]  out_rho_ok0;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4, busy4;
  logic [9:0]  in_x4, in_y4;
  logic [31:0] out_theta4;
  logic [39:0] out_rho4;
  logic [3:0]  out_rho_ok4;

  logic        in_valid6, in_ready6, out_valid6, out_ready6, out_last6, busy6;
  logic [9:0]  in_x6, in_y6;
  logic [7:0]  out_theta6;
  logic [5:0]  out_rho6;
  logic [0:0]  out_rho_ok6;

  int   checks;
  int   errors;
  exp_t q[$];
  int   rec_rho [180];
  bit   rec_ok  [180];

  hough_rho_sweep dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_x(in_x0), .in_y(in_y0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_theta(out_theta0), .out_rho(out_rho0), .out_rho_ok(out_rho_ok0),
    .out_last(out_last0), .busy(busy0)
  );

  hough_rho_sweep #(.LANES(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_x(in_x4), .in_y(in_y4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_theta(out_theta4), .out_rho(out_rho4), .out_rho_ok(out_rho_ok4),
    .out_last(out_last4), .busy(busy4)
  );

  hough_rho_sweep #(.RHOS(64)) dut64 (
    .clock(clock), .reset(reset), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_x(in_x6), .in_y(in_y6), .out_valid(out_valid6), .out_ready(out_ready6),
    .out_theta(out_theta6), .out_rho(out_rho6), .out_rho_ok(out_rho_ok6),
    .out_last(out_last6), .busy(busy6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int trig(input int t, input bit use_sin);
    real a;
    real v;
    a = 3.14159265358979323846 * real'(t) / 180.0;
    v = (use_sin ? $sin(a) : $cos(a)) * 4096.0;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic push_expected(input int x, input int y, input int rhos, input int lanes);
    exp_t   e;
    longint s;
    longint idx;
    for (int t = 0; t < 180; t++) begin
      s       = longint'(x) * longint'(trig(t, 1'b0)) + longint'(y) * longint'(trig(t, 1'b1));
      idx     = (s >>> 13) + longint'(rhos / 2);
      e.theta = t;
      e.ok    = (idx >= 0) && (idx < longint'(rhos));
      e.rho   = e.ok ? int'(idx) : 0;
      e.last  = (t >= 180 - lanes);
      q.push_back(e);
    end
  endtask

  task automatic sample(input int sel, output obs_t o);
    for (int k = 0; k < 4; k++) begin
      o.theta[k] = 0;
      o.rho[k]   = 0;
      o.ok[k]    = 1'b0;
    end
    case (sel)
      0: begin
        o.valid = out_valid0; o.last = out_last0; o.in_ready = in_ready0; o.busy = busy0;
        o.theta[0] = int'(out_theta0); o.rho[0] = int'(out_rho0); o.ok[0] = out_rho_ok0[0];
      end
      1: begin
        o.valid = out_valid4; o.last = out_last4; o.in_ready = in_ready4; o.busy = busy4;
        for (int k = 0; k < 4; k++) begin
          o.theta[k] = int'(out_theta4[k*8 +: 8]);
          o.rho[k]   = int'(out_rho4[k*10 +: 10]);
          o.ok[k]    = out_rho_ok4[k];
        end
      end
      default: begin
        o.valid = out_valid6; o.last = out_last6; o.in_ready = in_ready6; o.busy = busy6;
        o.theta[0] = int'(out_theta6); o.rho[0] = int'(out_rho6); o.ok[0] = out_rho_ok6[0];
      end
    endcase
  endtask

  task automatic drive_in(input int sel, input bit v, input int x, input int y);
    case (sel)
      0:       begin in_valid0 = v; in_x0 = 10'(x); in_y0 = 10'(y); end
      1:       begin in_valid4 = v; in_x4 = 10'(x); in_y4 = 10'(y); end
      default: begin in_valid6 = v; in_x6 = 10'(x); in_y6 = 10'(y); end
    endcase
  endtask

  task automatic drive_ready(input int sel, input bit r);
    case (sel)
      0:       out_ready0 = r;
      1:       out_ready4 = r;
      default: out_ready6 = r;
    endcase
  endtask

  function automatic logic [63:0] sig(input obs_t o);
    return {29'd0, o.valid, o.last, o.ok[0], 16'(o.theta[0]), 16'(o.rho[0])};
  endfunction

  // One pixel: handshake, then consume beats against the scoreboard until done or abort_at.
  task automatic run_pixel(input int sel, input int x, input int y, input bit stall, input int abort_at);
    int          lanes;
    int          rhos;
    int          groups;
    int          beats;
    int          edge_cnt;
    bit          seen;
    bit          stalled;
    bit          ready;
    logic [63:0] held;
    obs_t        o;
    exp_t        e;
    lanes  = (sel == 1) ? 4 : 1;
    rhos   = (sel == 2) ? 64 : 1024;
    groups = 180 / lanes;
    @(negedge clock);
    sample(sel, o);
    check("accept_in_ready", 64'(o.in_ready), 64'd1);
    drive_in(sel, 1'b1, x, y);
    push_expected(x, y, rhos, lanes);
    @(posedge clock);
    beats = 0; edge_cnt = 0; seen = 1'b0; stalled = 1'b0; held = '0;
    while (beats < groups && edge_cnt < 4000) begin
      @(negedge clock);
      drive_in(sel, (beats >= 10 && beats < 20), 999, 999);
      sample(sel, o);
      if (beats == abort_at) return;
      if (!seen && o.valid) begin
        seen = 1'b1;
        check("first_latency", 64'(edge_cnt), 64'd3);
      end
      if (stalled) check("stall_hold", sig(o), held);
      check("sweep_in_ready", 64'(o.in_ready), 64'd0);
      check("sweep_busy", 64'(o.busy), 64'd1);
      ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_ready(sel, ready);
      stalled = o.valid && !ready;
      held    = sig(o);
      if (o.valid && ready) begin
        for (int k = 0; k < lanes; k++) begin
          e = q.pop_front();
          check("theta", 64'(o.theta[k]), 64'(e.theta));
          check("rho", 64'(o.rho[k]), 64'(e.rho));
          check("rho_ok", 64'(o.ok[k]), 64'(e.ok));
          if (k == 0) check("last", 64'(o.last), 64'(e.last));
        end
        rec_rho[o.theta[0] % 180] = o.rho[0];
        rec_ok[o.theta[0] % 180]  = o.ok[0];
        beats++;
      end
      edge_cnt++;
    end
    check("beat_count", 64'(beats), 64'(groups));
    drive_ready(sel, 1'b1);
    @(negedge clock);
    sample(sel, o);
    check("post_in_ready", 64'(o.in_ready), 64'd1);
    check("post_busy", 64'(o.busy), 64'd0);
    check("post_valid", 64'(o.valid), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    obs_t o;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive_in(s, 1'b0, 0, 0);
      drive_ready(s, 1'b1);
    end
    repeat (3) @(negedge clock);
    sample(0, o);
    check("rst_out_valid", 64'(o.valid), 64'd0);
    check("rst_in_ready", 64'(o.in_ready), 64'd0);
    check("rst_busy", 64'(o.busy), 64'd0);
    check("rst_out_last", 64'(o.last), 64'd0);
    check("rst_out_theta", 64'(o.theta[0]), 64'd0);
    check("rst_out_rho", 64'(o.rho[0]), 64'd0);
    check("rst_out_ok", 64'(o.ok[0]), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rel_in_ready", 64'(in_ready0), 64'd1);

    run_pixel(0, 0, 0, 1'b0, -1);
    check("p00_rho_t0", 64'(rec_rho[0]), 64'd512);
    check("p00_rho_t179", 64'(rec_rho[179]), 64'd512);

    run_pixel(0, 100, 0, 1'b0, -1);
    check("p100_rho_t0", 64'(rec_rho[0]), 64'd562);
    check("p100_rho_t90", 64'(rec_rho[90]), 64'd512);
    check("p100_rho_t179", 64'(rec_rho[179]), 64'd462);

    run_pixel(0, 0, 200, 1'b0, -1);
    check("p0200_rho_t90", 64'(rec_rho[90]), 64'd612);
    check("p0200_rho_t0", 64'(rec_rho[0]), 64'd512);

    run_pixel(0, 100, 0, 1'b1, -1);
    check("stall_rho_t0", 64'(rec_rho[0]), 64'd562);
    check("stall_rho_t179", 64'(rec_rho[179]), 64'd462);

    run_pixel(1, 100, 0, 1'b0, -1);
    check("lanes4_rho_t0", 64'(rec_rho[0]), 64'd562);

    run_pixel(2, 1000, 0, 1'b0, -1);
    check("rhos64_ok_t0", 64'(rec_ok[0]), 64'd0);
    check("rhos64_rho_t0", 64'(rec_rho[0]), 64'd0);

    run_pixel(0, 100, 0, 1'b0, 50);
    #2 reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid0), 64'd0);
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_in_ready", 64'(in_ready0), 64'd0);
    q.delete();
    drive_in(0, 1'b0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_rel_in_ready", 64'(in_ready0), 64'd1);
    rec_rho[0] = -1;
    run_pixel(0, 100, 0, 1'b0, -1);
    check("after_abort_rho_t0", 64'(rec_rho[0]), 64'd562);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
